// File: rtl/serial_adder_pkg.sv
// ============================================================================
// serial_adder_pkg : shared FSM state type and sizing helpers for serial_adder
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 64;

  // Counter must be able to hold WIDTH itself, one past the last bit index.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
// ============================================================================
// fa_cell : combinational 1-bit full adder used as the serial adder's ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : bit-serial WIDTH-bit adder/subtractor, LSB first, one bit/clk
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_width_illegal
    $error("serial_adder: WIDTH out of range 2..64");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-1:0] w_res_nxt;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic             w_accept;

  fa_cell u_fa (
    .a  (r_a_sh[0]),
    .b  (r_b_sh[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_c)
  );

  // Only the upper WIDTH-1 result bits need storage; the final bit comes
  // straight from the adder on the completing edge.
  assign w_res_nxt = {w_s, r_res};
  assign w_last    = (r_cnt == LAST_BIT);
  assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_RUN);
      r_done <= (r_state == ST_RUN) && w_last;
      if (w_accept) begin
        r_a_sh  <= a;
        r_b_sh  <= sub ? ~b : b;
        r_carry <= sub ? 1'b1 : cin;
        r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
        r_a_sh  <= r_a_sh >> 1;
        r_b_sh  <= r_b_sh >> 1;
        r_res   <= w_res_nxt[WIDTH-1:1];
        r_carry <= w_c;
        r_cnt   <= r_cnt + 1'b1;
        // On the MSB cycle r_carry is the carry into bit WIDTH-1.
        if (w_last) begin
          r_sum  <= w_res_nxt;
          r_cout <= w_c;
          r_ovf  <= r_carry ^ w_c;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH 8 directed/random/handshake,
// WIDTH 4 exhaustive, WIDTH 2 and 64 random smoke.
`default_nettype none

module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] a_bus = '0;
  logic [63:0] b_bus = '0;
  logic        cin_i = 1'b0;
  logic        sub_i = 1'b0;
  logic        st8 = 1'b0, st4 = 1'b0, st2 = 1'b0, st64 = 1'b0;

  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        busy4, done4, cout4, ovf4;
  logic [3:0]  sum4;
  logic        busy2, done2, cout2, ovf2;
  logic [1:0]  sum2;
  logic        busy64, done64, cout64, ovf64;
  logic [63:0] sum64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a_bus[7:0]), .b(b_bus[7:0]),
    .cin(cin_i), .sub(sub_i), .busy(busy8), .done(done8), .sum(sum8),
    .cout(cout8), .ovf(ovf8));

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a(a_bus[3:0]), .b(b_bus[3:0]),
    .cin(cin_i), .sub(sub_i), .busy(busy4), .done(done4), .sum(sum4),
    .cout(cout4), .ovf(ovf4));

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .a(a_bus[1:0]), .b(b_bus[1:0]),
    .cin(cin_i), .sub(sub_i), .busy(busy2), .done(done2), .sum(sum2),
    .cout(cout2), .ovf(ovf2));

  serial_adder #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .start(st64), .a(a_bus), .b(b_bus),
    .cin(cin_i), .sub(sub_i), .busy(busy64), .done(done64), .sum(sum64),
    .cout(cout64), .ovf(ovf64));

  // ---------------- helpers ----------------
  function automatic logic [3:0] get_flags(input int w); // {busy,done,cout,ovf}
    case (w)
      8:       return {busy8, done8, cout8, ovf8};
      4:       return {busy4, done4, cout4, ovf4};
      2:       return {busy2, done2, cout2, ovf2};
      default: return {busy64, done64, cout64, ovf64};
    endcase
  endfunction

  function automatic logic [63:0] get_sum(input int w);
    case (w)
      8:       return {56'd0, sum8};
      4:       return {60'd0, sum4};
      2:       return {62'd0, sum2};
      default: return sum64;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      8:       st8 = v;
      4:       st4 = v;
      2:       st2 = v;
      default: st64 = v;
    endcase
  endtask

  function automatic logic [63:0] mask(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic signed [66:0] sext(input logic [63:0] v, input int w);
    logic signed [66:0] x;
    x = $signed({3'b000, v});
    if (v[w-1]) x = x - (67'sd1 <<< w);
    return x;
  endfunction

  // Reference: unsigned and signed arithmetic on whole operands.
  task automatic model(input int w, input logic [63:0] av, input logic [63:0] bv,
                       input logic ci, input logic sb,
                       output logic [63:0] s, output logic co, output logic ov);
    logic [64:0]        full;
    logic signed [66:0] r, hi, lo;
    logic [63:0]        m;
    m  = mask(w);
    av = av & m;
    bv = bv & m;
    if (sb) begin
      s  = (av - bv) & m;
      co = (av >= bv);
      r  = sext(av, w) - sext(bv, w);
    end else begin
      full = {1'b0, av} + {1'b0, bv} + {64'd0, ci};
      s    = full[63:0] & m;
      co   = full[w];
      r    = sext(av, w) + sext(bv, w) + (ci ? 67'sd1 : 67'sd0);
    end
    hi = (67'sd1 <<< (w - 1)) - 67'sd1;
    lo = -(67'sd1 <<< (w - 1));
    ov = (r > hi) || (r < lo);
  endtask

  // Issue one operation and wait (bounded) for its done pulse.
  task automatic run_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                        input logic ci, input logic sb,
                        output logic [63:0] s, output logic co, output logic ov,
                        output int lat, output int bc);
    logic [3:0] f;
    @(negedge clk);
    a_bus = av; b_bus = bv; cin_i = ci; sub_i = sb;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    a_bus = $urandom; b_bus = $urandom; cin_i = $urandom; sub_i = $urandom;
    lat = 0;
    f = get_flags(w);
    bc = f[3] ? 1 : 0;
    while (!f[2] && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      f = get_flags(w);
      if (f[3]) bc++;
    end
    s  = get_sum(w);
    co = f[1];
    ov = f[0];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy8, done8, cout8, ovf8, sum8} !== 12'd0) begin
      errors++;
      $display("FAIL reset_w8: got %h expected 000", {busy8, done8, cout8, ovf8, sum8});
    end
    checks++;
    if ({busy64, done64, cout64, ovf64, sum64} !== 68'd0) begin
      errors++;
      $display("FAIL reset_w64: got %h expected 0", {busy64, done64, cout64, ovf64, sum64});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [63:0] va[6], vb[6];
    logic        vc[6], vs[6];
    logic [9:0]  exp_r[6];
    logic [63:0] s;
    logic        co, ov;
    int          lat, bc;
    va = '{64'h0F, 64'hFF, 64'h7F, 64'h00, 64'h05, 64'h80};
    vb = '{64'h01, 64'h01, 64'h01, 64'h00, 64'h07, 64'h01};
    vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_r = '{{8'h10, 2'b00}, {8'h00, 2'b10}, {8'h80, 2'b01},
              {8'h01, 2'b00}, {8'hFE, 2'b00}, {8'h7F, 2'b11}};
    for (int i = 0; i < 6; i++) begin
      run_op(8, va[i], vb[i], vc[i], vs[i], s, co, ov, lat, bc);
      checks++;
      if ({s[7:0], co, ov} !== exp_r[i]) begin
        errors++;
        $display("FAIL directed_%0d: got sum/cout/ovf %h expected %h", i, {s[7:0], co, ov}, exp_r[i]);
      end
      if (i == 0) begin
        checks++;
        if (lat !== 8) begin
          errors++;
          $display("FAIL latency_w8: got %0d expected 8", lat);
        end
        checks++;
        if (bc !== 8) begin
          errors++;
          $display("FAIL busy_cycles_w8: got %0d expected 8", bc);
        end
        @(posedge clk); #1;
        checks++;
        if ({done8, busy8} !== 2'b00) begin
          errors++;
          $display("FAIL done_one_cycle: got done/busy %b expected 00", {done8, busy8});
        end
      end
    end
  endtask

  task automatic test_midrun_start();
    int lat;
    @(negedge clk);
    a_bus = 64'h12; b_bus = 64'h34; cin_i = 1'b0; sub_i = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 300) begin
      if (lat == 3) begin
        a_bus = 64'hFF; b_bus = 64'hFF; sub_i = 1'b1; st8 = 1'b1;
      end
      @(posedge clk); #1;
      st8 = 1'b0;
      lat++;
    end
    checks++;
    if ({sum8, cout8, ovf8, lat[7:0]} !== {8'h46, 2'b00, 8'd8}) begin
      errors++;
      $display("FAIL midrun_start: got sum %h cout %b ovf %b lat %0d expected 46 0 0 8",
               sum8, cout8, ovf8, lat);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy8, done8} !== 2'b00) begin
      errors++;
      $display("FAIL midrun_no_second_op: got busy/done %b expected 00", {busy8, done8});
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] s;
    logic        co, ov;
    int          lat, bc, lat2;
    run_op(8, 64'h33, 64'h44, 1'b0, 1'b0, s, co, ov, lat, bc);
    checks++;
    if (s[7:0] !== 8'h77) begin
      errors++;
      $display("FAIL b2b_first: got %h expected 77", s[7:0]);
    end
    a_bus = 64'h10; b_bus = 64'h20; cin_i = 1'b0; sub_i = 1'b0; st8 = 1'b1;
    lat2 = 0;
    do begin
      @(posedge clk); #1;
      st8 = 1'b0;
      lat2++;
    end while (!done8 && lat2 < 300);
    checks++;
    if (lat2 !== 9) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles expected 9", lat2);
    end
    checks++;
    if (sum8 !== 8'h30) begin
      errors++;
      $display("FAIL b2b_second: got %h expected 30", sum8);
    end
  endtask

  task automatic test_reset_midrun();
    logic [63:0] s;
    logic        co, ov;
    int          lat, bc, seen;
    @(negedge clk);
    a_bus = 64'h55; b_bus = 64'h22; cin_i = 1'b0; sub_i = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, cout8, ovf8, sum8} !== 12'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 000", {busy8, done8, cout8, ovf8, sum8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d active cycles expected 0", seen);
    end
    run_op(8, 64'h21, 64'h09, 1'b1, 1'b0, s, co, ov, lat, bc);
    checks++;
    if ({s[7:0], co, ov, lat[7:0]} !== {8'h2B, 2'b00, 8'd8}) begin
      errors++;
      $display("FAIL post_reset_op: got sum %h lat %0d expected 2b lat 8", s[7:0], lat);
    end
  endtask

  task automatic test_random(input int w, input int n);
    logic [63:0] av, bv, s, es;
    logic        ci, sb, co, ov, eco, eov;
    int          lat, bc;
    for (int i = 0; i < n; i++) begin
      av = {$urandom, $urandom};
      bv = {$urandom, $urandom};
      if (i % 5 == 0) bv = av;
      ci = $urandom;
      sb = $urandom;
      model(w, av, bv, ci, sb, es, eco, eov);
      run_op(w, av, bv, ci, sb, s, co, ov, lat, bc);
      checks++;
      if ({s, co, ov} !== {es, eco, eov} || lat != w) begin
        errors++;
        $display("FAIL random_w%0d: a %h b %h cin %b sub %b got %h/%b/%b lat %0d expected %h/%b/%b lat %0d",
                 w, av & mask(w), bv & mask(w), ci, sb, s, co, ov, lat, es, eco, eov, w);
      end
    end
  endtask

  task automatic test_exhaustive_w4();
    logic [63:0] s, es;
    logic        co, ov, eco, eov;
    int          lat, bc;
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int k = 0; k < 4; k++) begin
          model(4, 64'(av), 64'(bv), k[0], k[1], es, eco, eov);
          run_op(4, 64'(av), 64'(bv), k[0], k[1], s, co, ov, lat, bc);
          checks++;
          if ({s, co, ov} !== {es, eco, eov} || lat != 4) begin
            errors++;
            $display("FAIL exhaustive_w4: a %0d b %0d cin %b sub %b got %h/%b/%b lat %0d expected %h/%b/%b",
                     av, bv, k[0], k[1], s, co, ov, lat, es, eco, eov);
          end
        end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_midrun_start();
    test_back_to_back();
    test_reset_midrun();
    test_random(8, 40);
    test_random(2, 12);
    test_random(64, 20);
    test_exhaustive_w4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
